// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain stage and its downstream consumers.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH_DEFAULT = 8;
  localparam int DRAIN_DEPTH             = 2;

  typedef logic [1:0] drain_occ_t;

  typedef struct packed {
    logic                               valid;
    logic [FIFO_DATA_WIDTH_DEFAULT-1:0] data;
  } fifo_stream_t;

  // A new pop is safe only if the returning word still has a slot after this cycle's dequeue.
  function automatic logic drain_pop_allowed(input drain_occ_t occ, input logic inflight,
                                             input logic deq);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
    return (pending < 3'(DRAIN_DEPTH));
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry output buffer: entry 0 is the head, entry 1 the skid slot.
// Dequeue is applied before capture so a returning word lands in the first free entry.
module drain_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = FIFO_DATA_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         deq_i,
  input  logic         cap_i,
  input  logic [W-1:0] cap_data_i,
  output drain_occ_t   occ_o,
  output logic [W-1:0] head_o
);

  drain_occ_t   occ_q, occ_d, occ_deq_s;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;

  // Next-state: clear wins, otherwise shift on dequeue then place the captured word.
  always_comb begin
    occ_d     = occ_q;
    e0_d      = e0_q;
    e1_d      = e1_q;
    occ_deq_s = occ_q - {1'b0, deq_i};
    if (clr_i) begin
      occ_d = 2'd0;
      e0_d  = {W{1'b0}};
      e1_d  = {W{1'b0}};
    end else begin
      if (deq_i) begin
        e0_d = e1_q;
        e1_d = {W{1'b0}};
      end else begin
        e0_d = e0_q;
        e1_d = e1_q;
      end
      if (cap_i) begin
        if (occ_deq_s == 2'd0) begin
          e0_d = cap_data_i;
        end else begin
          e1_d = cap_data_i;
        end
      end else begin
        e0_d = e0_d;
      end
      occ_d = occ_deq_s + {1'b0, cap_i};
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= 2'd0;
      e0_q  <= {W{1'b0}};
      e1_q  <= {W{1'b0}};
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = e0_q;

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a registered-read FIFO into a valid/ready stream at one word per cycle.
// Optional DRAIN_FLUSH_EN adds a flush input that discards buffered and in-flight words.
module fifo_stream_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef DRAIN_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  m_ready
);

  logic       cs_q;
  logic       inflight_q, inflight_d;
  logic       deq_s, cap_s, clr_s, pop_s;
  drain_occ_t occ_s;

`ifdef DRAIN_FLUSH_EN
  logic discard_q;

  // One-cycle discard window so nothing from before the flush edge is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_q <= 1'b0;
    end else begin
      discard_q <= flush;
    end
  end

  assign clr_s = flush;
  assign cap_s = inflight_q & ~discard_q;
`else
  assign clr_s = 1'b0;
  assign cap_s = inflight_q;
`endif

  assign m_valid = (occ_s != 2'd0);
  assign deq_s   = m_valid & m_ready;

  // Pop decision uses this cycle's sink acceptance so steady state keeps one pop per cycle.
  always_comb begin
    pop_s = 1'b0;
    if (cs_q && !fifo_empty && !clr_s) begin
      pop_s = drain_pop_allowed(occ_s, inflight_q, deq_s);
    end else begin
      pop_s = 1'b0;
    end
    inflight_d = pop_s;
  end

  // Chip select and in-flight tracking; a pop pending at reset is simply abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q       <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      cs_q       <= 1'b1;
      inflight_q <= inflight_d;
    end
  end

  assign fifo_rd_cs = cs_q;
  assign fifo_rd_en = pop_s;

  drain_skid_buf #(
    .W(DATA_WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_s),
    .deq_i      (deq_s),
    .cap_i      (cap_s),
    .cap_data_i (fifo_data),
    .occ_o      (occ_s),
    .head_o     (m_data)
  );

endmodule
